exec_unit: RTL
==============

# exec_unit

Parametrised execute unit for the next multicycle core, replacing the fixed 32-bit arith/branch-compare pair. It accepts one RV32I-style operation per valid/ready handshake and computes either an ALU result or a branch decision. Coverage includes signed SLT/BLT/BGE, SUB and SRA. Shifts run on an iterative shifter of configurable step width, so area can be traded for latency, and the result is held under output back-pressure.

## Interface
- XLEN, 32: operand/result width; power of two, ≥ 8
- SHIFT_STEP, 1: bits shifted per cycle; power of two, 1..XLEN
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- in_op  in  3  funct3 encoding
- in_alt  in  1  funct7[5]: SUB for op 000, SRA for op 101
- in_br  in  1  1 = branch compare, 0 = ALU op
- in_x  in  XLEN  left operand
- in_y  in  XLEN  right operand / shift amount
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  XLEN  ALU result; 0 in branch mode
- out_taken  out  1  branch condition; 0 in ALU mode

## Operation
- States: IDLE, SHIFT, DONE.
- Accept when in_valid && in_ready. Operands, op, alt and br are latched.
- in_ready = resetn && (state==IDLE || (state==DONE && out_ready)). This allows back-to-back accepts at one op per cycle.
- ALU ops (in_br=0):
  - 000: ADD, or SUB when alt=1.
  - 001: SLL.
  - 010: SLT, signed, result 0/1.
  - 011: SLTU, result 0/1.
  - 100: XOR.
  - 101: SRL, or SRA when alt=1.
  - 110: OR.
  - 111: AND.
  - alt is ignored for all other ops. Add/sub wraps modulo 2^XLEN.
- Shift amount: shamt = in_y[log2(XLEN)-1:0]. Upper bits are ignored.
- Non-shift ops, or shift with shamt==0: go to DONE on the accept edge.
- Shift with shamt>0: go to SHIFT with remaining=shamt. Each cycle shifts by min(SHIFT_STEP, remaining). SRA fills with the latched sign bit. Go to DONE when remaining reaches 0.
- Branch ops (in_br=1, never iterative):
  - 000: BEQ. 001: BNE.
  - 100: BLT, signed. 101: BGE, signed.
  - 110: BLTU. 111: BGEU.
  - 010 and 011 give taken=0.
- DONE: out_valid=1. out_data and out_taken stay stable until out_valid && out_ready.
  - Handshake with no new accept: return to IDLE.
  - Handshake with a simultaneous accept: start the new op directly.

## Timing
- Reset (resetn low at an edge): state IDLE, out_valid 0, out_data 0, out_taken 0, shifter cleared. in_ready is 0 while resetn is low and 1 in the first cycle after release.
- Latency from the accept edge to out_valid high:
  - Non-shift op: 1 cycle.
  - Shift: 1 + ceil(shamt/SHIFT_STEP) cycles.
- in_ready is low throughout SHIFT and while DONE is stalled.
- Reset mid-SHIFT or in DONE: operation is discarded with no output. out_valid is 0 after the next edge.
- in_valid while not ready: ignored. The source must hold the operation.

## Structure
- Package exec_pkg holds:
  - funct3 localparams ALU_ADD…ALU_AND and BR_BEQ…BR_BGEU;
  - the state enum (IDLE/SHIFT/DONE).
- Sub-module exec_shifter (XLEN, SHIFT_STEP):
  - loads value, shamt, direction and arithmetic flag;
  - steps once per cycle and flags done;
  - combinational remainder only.
- exec_unit holds the FSM, handshake, ALU and compare logic, and output registers.

## Test plan
- ADD/SUB: x=0x7FFFFFFF, y=1, ADD → 0x80000000 with out_valid one cycle after accept. x=0, y=1, SUB → 0xFFFFFFFF.
- Signed compares: x=0xFFFFFFFF, y=1 → SLT 1, SLTU 0. Branch x=0xFFFFFFFE, y=1 → BLT taken 1, BLTU 0. BGE with x==y → taken 1. Branch op 010 → taken 0, out_data 0.
- Iterative shift:
  - SHIFT_STEP=1: SRA x=0x80000000, y=31 → 0xFFFFFFFF after 32 cycles, with in_ready low throughout.
  - SHIFT_STEP=4: same op gives out_valid after 9 cycles.
  - SLL x=1, y=0x21 → 0x2 (shamt=1).
- Back-pressure: hold out_ready low for 3 cycles in DONE → out_data held and in_ready low. Then raise out_ready with in_valid high → new op accepted in that same cycle, and its AND result is valid on the next cycle.
- Throughput: stream 8 non-shift ops with out_ready tied high → one result per cycle, in order, no bubbles.
- Reset mid-operation: drop resetn during SHIFT → out_valid 0 after the edge, in_ready 1 after release, no stale result appears.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for the execute unit: funct3 encodings for ALU and
// branch operations, operation field width and the control FSM states.
package exec_pkg;

  localparam int unsigned OP_W = 3;

  // ALU funct3 encodings (alt selects SUB for ADD and SRA for SRL)
  localparam logic [OP_W-1:0] ALU_ADD  = 3'b000;
  localparam logic [OP_W-1:0] ALU_SLL  = 3'b001;
  localparam logic [OP_W-1:0] ALU_SLT  = 3'b010;
  localparam logic [OP_W-1:0] ALU_SLTU = 3'b011;
  localparam logic [OP_W-1:0] ALU_XOR  = 3'b100;
  localparam logic [OP_W-1:0] ALU_SRL  = 3'b101;
  localparam logic [OP_W-1:0] ALU_OR   = 3'b110;
  localparam logic [OP_W-1:0] ALU_AND  = 3'b111;

  // Branch funct3 encodings (010/011 are unused and never taken)
  localparam logic [OP_W-1:0] BR_BEQ  = 3'b000;
  localparam logic [OP_W-1:0] BR_BNE  = 3'b001;
  localparam logic [OP_W-1:0] BR_BLT  = 3'b100;
  localparam logic [OP_W-1:0] BR_BGE  = 3'b101;
  localparam logic [OP_W-1:0] BR_BLTU = 3'b110;
  localparam logic [OP_W-1:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/exec_if.sv
// Operation/result handshake bundle of the execute unit.
// master: operation source and result consumer; slave: the execute unit.
//   in_valid/in_ready  operation handshake; in_op/in_alt/in_br/in_x/in_y payload
//   out_valid/out_ready result handshake; out_data (ALU), out_taken (branch)
interface exec_if
  import exec_pkg::*;
#(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic            in_alt;
  logic            in_br;
  logic [XLEN-1:0] in_x;
  logic [XLEN-1:0] in_y;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            out_taken;

  modport master (
    output in_valid, in_op, in_alt, in_br, in_x, in_y, out_ready,
    input  in_ready, out_valid, out_data, out_taken
  );

  modport slave (
    input  in_valid, in_op, in_alt, in_br, in_x, in_y, out_ready,
    output in_ready, out_valid, out_data, out_taken
  );
endinterface

// File: rtl/exec_shifter.sv
// Iterative shifter: shifts by up to SHIFT_STEP bits per cycle.
//   clk, resetn         clock, synchronous active-low clear
//   load                capture in_value/in_shamt/left/arith
//   step                perform one step on the held value
//   next_value          value after the current step (combinational)
//   last                current step consumes the remaining amount
module exec_shifter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     load,
  input  logic                     step,
  input  logic [XLEN-1:0]          in_value,
  input  logic [$clog2(XLEN)-1:0]  in_shamt,
  input  logic                     left,
  input  logic                     arith,
  output logic [XLEN-1:0]          next_value,
  output logic                     last
);
  localparam int unsigned SHW = $clog2(XLEN);
  // One extra bit so SHIFT_STEP == XLEN is representable
  localparam int unsigned CW  = SHW + 1;

  logic [XLEN-1:0] value;
  logic [SHW-1:0]  rem;
  logic            left_q;
  logic            arith_q;
  logic [CW-1:0]   rem_w;
  logic [CW-1:0]   amt_c;

  assign rem_w = CW'(rem);
  assign amt_c = (rem_w > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : rem_w;
  assign last  = (rem_w <= CW'(SHIFT_STEP));

  // Arithmetic right shift replicates the sign bit captured at load
  always_comb begin
    next_value = value >> amt_c;
    if (left_q) begin
      next_value = value << amt_c;
    end else if (arith_q) begin
      next_value = $unsigned($signed(value) >>> amt_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      value   <= '0;
      rem     <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      value   <= in_value;
      rem     <= in_shamt;
      left_q  <= left;
      arith_q <= arith;
    end else if (step) begin
      value   <= next_value;
      rem     <= rem - SHW'(amt_c);
    end
  end
endmodule

// File: rtl/exec_unit.sv
// Execute unit: one RV32I-style ALU or branch-compare op per handshake.
// Shifts use an iterative shifter; the result is held until consumed.
//   clk, resetn  clock, synchronous active-low reset
//   bus          exec_if slave: operation in, result out
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input logic  clk,
  input logic  resetn,
  exec_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  state_t          state;
  logic            accept_c;
  logic            is_shift_c;
  logic            start_shift_c;
  logic            step_c;
  logic            sh_last_c;
  logic [SHW-1:0]  shamt_c;
  logic [XLEN-1:0] alu_c;
  logic [XLEN-1:0] sh_next_c;
  logic            br_c;

  // Ready when idle, or when the held result is being consumed this cycle
  assign bus.in_ready  = resetn && (state == IDLE || (state == DONE && bus.out_ready));
  assign accept_c      = bus.in_valid && bus.in_ready;
  assign shamt_c       = bus.in_y[SHW-1:0];
  assign is_shift_c    = !bus.in_br && (bus.in_op == ALU_SLL || bus.in_op == ALU_SRL);
  assign start_shift_c = accept_c && is_shift_c && (shamt_c != '0);
  assign step_c        = (state == SHIFT);

  exec_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk        (clk),
    .resetn     (resetn),
    .load       (start_shift_c),
    .step       (step_c),
    .in_value   (bus.in_x),
    .in_shamt   (shamt_c),
    .left       (bus.in_op == ALU_SLL),
    .arith      (bus.in_alt),
    .next_value (sh_next_c),
    .last       (sh_last_c)
  );

  // Single-cycle ALU; a shift by zero passes the operand through
  always_comb begin
    alu_c = '0;
    case (bus.in_op)
      ALU_ADD:          alu_c = bus.in_alt ? bus.in_x - bus.in_y : bus.in_x + bus.in_y;
      ALU_SLL, ALU_SRL: alu_c = bus.in_x;
      ALU_SLT:          alu_c = XLEN'($signed(bus.in_x) < $signed(bus.in_y));
      ALU_SLTU:         alu_c = XLEN'(bus.in_x < bus.in_y);
      ALU_XOR:          alu_c = bus.in_x ^ bus.in_y;
      ALU_OR:           alu_c = bus.in_x | bus.in_y;
      ALU_AND:          alu_c = bus.in_x & bus.in_y;
      default:          alu_c = '0;
    endcase
  end

  // Branch condition
  always_comb begin
    br_c = 1'b0;
    case (bus.in_op)
      BR_BEQ:  br_c = (bus.in_x == bus.in_y);
      BR_BNE:  br_c = (bus.in_x != bus.in_y);
      BR_BLT:  br_c = ($signed(bus.in_x) < $signed(bus.in_y));
      BR_BGE:  br_c = ($signed(bus.in_x) >= $signed(bus.in_y));
      BR_BLTU: br_c = (bus.in_x < bus.in_y);
      BR_BGEU: br_c = (bus.in_x >= bus.in_y);
      default: br_c = 1'b0;
    endcase
  end

  // Control FSM and result registers; an accept restarts from any ready state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_taken <= 1'b0;
    end else if (accept_c) begin
      bus.out_taken <= bus.in_br ? br_c : 1'b0;
      if (start_shift_c) begin
        state         <= SHIFT;
        bus.out_valid <= 1'b0;
        bus.out_data  <= '0;
      end else begin
        state         <= DONE;
        bus.out_valid <= 1'b1;
        bus.out_data  <= bus.in_br ? '0 : alu_c;
      end
    end else begin
      case (state)
        SHIFT: begin
          if (sh_last_c) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.out_data  <= sh_next_c;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
